// File: rtl/cr_huf_comp_htb_sched.sv
// In-order scheduler for the short Huffman tree-builder pipes: round-robin dispatch, in-order retire.
// Optional per-pipe dispatch and stall counters are enabled by defining CR_HUF_COMP_HTB_SCHED_STATS_EN.
module cr_huf_comp_htb_sched #(
    parameter int NUM_PIPES = 2,
    parameter int SEQID_W   = 8,
    parameter int PTR_W     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [SEQID_W-1:0]      req_seq_id,
    output logic                    req_ready,
    input  logic [NUM_PIPES-1:0]    sw_pipe_disable,
    input  logic [NUM_PIPES-1:0]    pipe_not_ready,
    output logic [NUM_PIPES-1:0]    pipe_start,
    output logic [SEQID_W-1:0]      pipe_start_seq_id,
    input  logic [NUM_PIPES-1:0]    pipe_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_PIPES-1:0]    out_pipe_sel,
    output logic [SEQID_W-1:0]      out_seq_id,
`ifdef CR_HUF_COMP_HTB_SCHED_STATS_EN
    output logic [NUM_PIPES*16-1:0] stat_dispatch_cnt,
    output logic [15:0]             stat_stall_cnt,
`endif
    output logic                    err_spurious_done
);

    localparam int DEPTH = 2 ** PTR_W;
    localparam logic [PTR_W:0] NP_W = (PTR_W+1)'(NUM_PIPES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } pipe_st_e;

    // Pipe index addition modulo NUM_PIPES; both operands are below NUM_PIPES
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input logic [PTR_W-1:0] b);
        logic [PTR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = (s >= NP_W) ? (s - NP_W) : s;
        return s[PTR_W-1:0];
    endfunction

    pipe_st_e             st_q [NUM_PIPES];
    pipe_st_e             st_d [NUM_PIPES];
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [PTR_W-1:0]     fifo_idx_q [DEPTH];
    logic [SEQID_W-1:0]   fifo_seq_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       cnt_q, cnt_d;
    logic [NUM_PIPES-1:0] pipe_start_q, pipe_start_d;
    logic [SEQID_W-1:0]   start_seq_q, start_seq_d;
    logic                 out_valid_q, out_valid_d;
    logic [NUM_PIPES-1:0] out_sel_q, out_sel_d;
    logic [SEQID_W-1:0]   out_seq_q, out_seq_d;
    logic                 err_q, err_d;

    logic [DEPTH-1:0]     elig_s;
    logic [PTR_W-1:0]     grant_s, cand_s, head_s, pop_ptr_s, nxt_head_s;
    logic [SEQID_W-1:0]   nxt_seq_s;
    logic [PTR_W:0]       remain_s;
    logic                 accept_s, retire_s, nxt_done_s, spur_s;

    // Eligibility per pipe and round-robin grant search starting at the pointer
    always_comb begin
        elig_s  = '0;
        grant_s = '0;
        cand_s  = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            elig_s[i] = (st_q[i] == ST_IDLE) && !pipe_not_ready[i] && ((i == 0) || !sw_pipe_disable[i]);
        end
        // Descending scan so the smallest offset from the pointer wins
        for (int k = NUM_PIPES - 1; k >= 0; k--) begin
            cand_s  = wrap_add(rr_q, PTR_W'(k));
            grant_s = elig_s[cand_s] ? cand_s : grant_s;
        end
    end

    assign req_ready = |elig_s;
    assign accept_s  = req_valid && req_ready;
    assign retire_s  = out_valid_q && out_ready;
    assign head_s    = fifo_idx_q[rd_ptr_q];
    assign pop_ptr_s = rd_ptr_q + PTR_W'(retire_s);

    // Pipe FSMs, order-FIFO occupancy and next values of the registered outputs
    always_comb begin
        spur_s       = 1'b0;
        nxt_done_s   = 1'b0;
        pipe_start_d = '0;
        out_sel_d    = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            st_d[i] = st_q[i];
            case (st_q[i])
                ST_IDLE: st_d[i] = (accept_s && (grant_s == PTR_W'(i))) ? ST_BUSY : ST_IDLE;
                ST_BUSY: st_d[i] = pipe_done[i] ? ST_DONE : ST_BUSY;
                ST_DONE: st_d[i] = (retire_s && (head_s == PTR_W'(i))) ? ST_IDLE : ST_DONE;
                default: st_d[i] = ST_IDLE;
            endcase
            spur_s          = spur_s || (pipe_done[i] && (st_q[i] != ST_BUSY));
            pipe_start_d[i] = accept_s && (grant_s == PTR_W'(i));
        end
        rr_d     = accept_s ? wrap_add(grant_s, PTR_W'(1)) : rr_q;
        cnt_d    = cnt_q + (PTR_W+1)'(accept_s) - (PTR_W+1)'(retire_s);
        remain_s = cnt_q - (PTR_W+1)'(retire_s);
        // An empty FIFO after the pop means the entry being pushed becomes the head
        nxt_head_s = (remain_s == '0) ? grant_s : fifo_idx_q[pop_ptr_s];
        nxt_seq_s  = (remain_s == '0) ? req_seq_id : fifo_seq_q[pop_ptr_s];
        for (int i = 0; i < NUM_PIPES; i++) begin
            nxt_done_s = nxt_done_s || ((st_d[i] == ST_DONE) && (nxt_head_s == PTR_W'(i)));
        end
        out_valid_d = (cnt_d != '0) && nxt_done_s;
        for (int i = 0; i < NUM_PIPES; i++) begin
            out_sel_d[i] = out_valid_d && (nxt_head_s == PTR_W'(i));
        end
        out_seq_d   = out_valid_d ? nxt_seq_s : '0;
        start_seq_d = accept_s ? req_seq_id : '0;
        err_d       = err_q || spur_s;
    end

    // State, order FIFO and registered output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                st_q[i] <= ST_IDLE;
            end
            for (int d = 0; d < DEPTH; d++) begin
                fifo_idx_q[d] <= '0;
                fifo_seq_q[d] <= '0;
            end
            rr_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            pipe_start_q <= '0;
            start_seq_q  <= '0;
            out_valid_q  <= 1'b0;
            out_sel_q    <= '0;
            out_seq_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                st_q[i] <= st_d[i];
            end
            if (accept_s) begin
                fifo_idx_q[wr_ptr_q] <= grant_s;
                fifo_seq_q[wr_ptr_q] <= req_seq_id;
            end
            rr_q         <= rr_d;
            wr_ptr_q     <= wr_ptr_q + PTR_W'(accept_s);
            rd_ptr_q     <= pop_ptr_s;
            cnt_q        <= cnt_d;
            pipe_start_q <= pipe_start_d;
            start_seq_q  <= start_seq_d;
            out_valid_q  <= out_valid_d;
            out_sel_q    <= out_sel_d;
            out_seq_q    <= out_seq_d;
            err_q        <= err_d;
        end
    end

    assign pipe_start        = pipe_start_q;
    assign pipe_start_seq_id = start_seq_q;
    assign out_valid         = out_valid_q;
    assign out_pipe_sel      = out_sel_q;
    assign out_seq_id        = out_seq_q;
    assign err_spurious_done = err_q;

`ifdef CR_HUF_COMP_HTB_SCHED_STATS_EN
    logic [15:0] disp_cnt_q [NUM_PIPES];
    logic [15:0] stall_cnt_q;

    // Saturating per-pipe dispatch counters and request stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                disp_cnt_q[i] <= 16'd0;
            end
            stall_cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                disp_cnt_q[i] <= (pipe_start_q[i] && (disp_cnt_q[i] != 16'hFFFF)) ?
                                 (disp_cnt_q[i] + 16'd1) : disp_cnt_q[i];
            end
            stall_cnt_q <= (req_valid && !req_ready && (stall_cnt_q != 16'hFFFF)) ?
                           (stall_cnt_q + 16'd1) : stall_cnt_q;
        end
    end

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_stat
        assign stat_dispatch_cnt[g*16 +: 16] = disp_cnt_q[g];
    end
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cr_huf_comp_htb_sched.sv
// Bench for cr_huf_comp_htb_sched: dispatch vector table, directed ordering/back-pressure/reset
// sequences, and a random run checked against a job-queue reference model.
module tb_cr_huf_comp_htb_sched;
    localparam int NP = 2;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_seq_id = 8'h00;
    logic          req_ready;
    logic [NP-1:0] sw_pipe_disable = 2'b00;
    logic [NP-1:0] pipe_not_ready = 2'b00;
    logic [NP-1:0] pipe_start;
    logic [SW-1:0] pipe_start_seq_id;
    logic [NP-1:0] pipe_done = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NP-1:0] out_pipe_sel;
    logic [SW-1:0] out_seq_id;
    logic          err_spurious_done;
`ifdef CR_HUF_COMP_HTB_SCHED_STATS_EN
    logic [NP*16-1:0] stat_dispatch_cnt;
    logic [15:0]      stat_stall_cnt;
`endif

    cr_huf_comp_htb_sched #(.NUM_PIPES(NP), .SEQID_W(SW), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_seq_id(req_seq_id), .req_ready(req_ready),
        .sw_pipe_disable(sw_pipe_disable), .pipe_not_ready(pipe_not_ready),
        .pipe_start(pipe_start), .pipe_start_seq_id(pipe_start_seq_id),
        .pipe_done(pipe_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pipe_sel(out_pipe_sel), .out_seq_id(out_seq_id),
`ifdef CR_HUF_COMP_HTB_SCHED_STATS_EN
        .stat_dispatch_cnt(stat_dispatch_cnt), .stat_stall_cnt(stat_stall_cnt),
`endif
        .err_spurious_done(err_spurious_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] dis;
        logic [1:0] pnr;
        logic       rdy;
        logic [1:0] start;
    } vec_t;
    vec_t vt [8];

    // reference model: which pipes hold a job, which have finished, dispatch-order queue
    bit       owned [NP];
    bit       fin [NP];
    int       rr_m;
    int       qp [$];
    int       qs [$];
    bit       m_valid;
    int       grant;
    int       m_p;
    bit       exp_rdy;
    int       exp_start;
    int       exp_sseq;
    logic [NP-1:0] pd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_seq_id = 8'h00;
        sw_pipe_disable = 2'b00;
        pipe_not_ready = 2'b00;
        pipe_done = 2'b00;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{2'b00, 2'b00, 1'b1, 2'b01};
        vt[1] = '{2'b10, 2'b00, 1'b1, 2'b01};
        vt[2] = '{2'b01, 2'b01, 1'b1, 2'b10};
        vt[3] = '{2'b00, 2'b01, 1'b1, 2'b10};
        vt[4] = '{2'b10, 2'b01, 1'b0, 2'b00};
        vt[5] = '{2'b01, 2'b11, 1'b0, 2'b00};
        vt[6] = '{2'b11, 2'b00, 1'b1, 2'b01};
        vt[7] = '{2'b00, 2'b10, 1'b1, 2'b01};

        // single dispatch from reset under each disable/back-pressure mix
        for (int v = 0; v < 8; v++) begin
            do_reset();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_pipe_start", 32'(pipe_start), 32'd0);
            chk("rst_err", 32'(err_spurious_done), 32'd0);
            sw_pipe_disable = vt[v].dis;
            pipe_not_ready = vt[v].pnr;
            req_valid = 1'b1;
            req_seq_id = 8'(8'h60 + v);
            #1;
            chk("tbl_ready", 32'(req_ready), 32'(vt[v].rdy));
            cyc();
            req_valid = 1'b0;
            chk("tbl_start", 32'(pipe_start), 32'(vt[v].start));
            chk("tbl_start_seq", 32'(pipe_start_seq_id), vt[v].rdy ? 32'(8'h60 + v) : 32'd0);
        end

        // basic round robin, each job finished before the next
        do_reset();
        for (int j = 0; j < 3; j++) begin
            req_valid = 1'b1;
            req_seq_id = 8'(8'h10 + j);
            cyc();
            req_valid = 1'b0;
            chk("rr_start", 32'(pipe_start), (j == 1) ? 32'd2 : 32'd1);
            chk("rr_start_seq", 32'(pipe_start_seq_id), 32'(8'h10 + j));
            pipe_done = (j == 1) ? 2'b10 : 2'b01;
            cyc();
            pipe_done = 2'b00;
            chk("rr_pulse_len", 32'(pipe_start), 32'd0);
            chk("rr_out_valid", 32'(out_valid), 32'd1);
            chk("rr_out_seq", 32'(out_seq_id), 32'(8'h10 + j));
            chk("rr_out_sel", 32'(out_pipe_sel), (j == 1) ? 32'd2 : 32'd1);
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
            chk("rr_out_clear", 32'(out_valid), 32'd0);
        end

        // out-of-order completion retires in dispatch order
        do_reset();
        req_valid = 1'b1;
        req_seq_id = 8'h20;
        cyc();
        req_seq_id = 8'h21;
        cyc();
        req_valid = 1'b0;
        pipe_done = 2'b10;
        cyc();
        pipe_done = 2'b00;
        for (int j = 0; j < 4; j++) begin
            chk("ooo_hold_valid", 32'(out_valid), 32'd0);
            cyc();
        end
        pipe_done = 2'b01;
        cyc();
        pipe_done = 2'b00;
        chk("ooo_first_valid", 32'(out_valid), 32'd1);
        chk("ooo_first_seq", 32'(out_seq_id), 32'h20);
        chk("ooo_first_sel", 32'(out_pipe_sel), 32'd1);
        out_ready = 1'b1;
        cyc();
        chk("ooo_b2b_valid", 32'(out_valid), 32'd1);
        chk("ooo_b2b_seq", 32'(out_seq_id), 32'h21);
        chk("ooo_b2b_sel", 32'(out_pipe_sel), 32'd2);
        cyc();
        out_ready = 1'b0;
        chk("ooo_drained", 32'(out_valid), 32'd0);

        // back-pressure on both sides
        do_reset();
        req_valid = 1'b1;
        req_seq_id = 8'h30;
        cyc();
        req_seq_id = 8'h31;
        cyc();
        req_seq_id = 8'h32;
        #1;
        chk("bp_ready_busy", 32'(req_ready), 32'd0);
        pipe_done = 2'b11;
        cyc();
        pipe_done = 2'b00;
        chk("bp_ready_done", 32'(req_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_seq", 32'(out_seq_id), 32'h30);
            chk("bp_hold_sel", 32'(out_pipe_sel), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_retire_cycle", 32'(req_ready), 32'd0);
        cyc();
        out_ready = 1'b0;
        chk("bp_ready_back", 32'(req_ready), 32'd1);
        chk("bp_next_seq", 32'(out_seq_id), 32'h31);
        chk("bp_next_sel", 32'(out_pipe_sel), 32'd2);
        cyc();
        req_valid = 1'b0;
        chk("bp_redispatch", 32'(pipe_start), 32'd1);
        chk("bp_redispatch_seq", 32'(pipe_start_seq_id), 32'h32);

        // pipe1 disabled, bit0 of the disable ignored
        do_reset();
        sw_pipe_disable = 2'b11;
        for (int j = 0; j < 4; j++) begin
            req_valid = 1'b1;
            req_seq_id = 8'(8'h40 + j);
            cyc();
            req_valid = 1'b0;
            chk("dis_start", 32'(pipe_start), 32'd1);
            pipe_done = 2'b01;
            cyc();
            pipe_done = 2'b00;
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
        end
        sw_pipe_disable = 2'b00;

        // spurious done and reset in the middle of jobs
        do_reset();
        chk("sp_err_rst", 32'(err_spurious_done), 32'd0);
        pipe_done = 2'b10;
        cyc();
        pipe_done = 2'b00;
        chk("sp_err_set", 32'(err_spurious_done), 32'd1);
        cyc();
        chk("sp_err_sticky", 32'(err_spurious_done), 32'd1);
        req_valid = 1'b1;
        req_seq_id = 8'h50;
        cyc();
        req_seq_id = 8'h51;
        cyc();
        req_valid = 1'b0;
        pipe_done = 2'b01;
        cyc();
        pipe_done = 2'b00;
        chk("sp_out_seq", 32'(out_seq_id), 32'h50);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_seq_id = 8'h52;
        cyc();
        req_valid = 1'b0;
        chk("sp_pre_start", 32'(pipe_start), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_start", 32'(pipe_start), 32'd0);
        chk("mid_rst_start_seq", 32'(pipe_start_seq_id), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sel", 32'(out_pipe_sel), 32'd0);
        chk("mid_rst_seq", 32'(out_seq_id), 32'd0);
        chk("mid_rst_err", 32'(err_spurious_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pipe_done = 2'b10;
        cyc();
        pipe_done = 2'b00;
        chk("late_done_err", 32'(err_spurious_done), 32'd1);
        chk("late_done_valid", 32'(out_valid), 32'd0);
        req_valid = 1'b1;
        req_seq_id = 8'h53;
        cyc();
        req_valid = 1'b0;
        chk("post_rst_pipe0", 32'(pipe_start), 32'd1);
        pipe_done = 2'b01;
        cyc();
        pipe_done = 2'b00;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_seq", 32'(out_seq_id), 32'h53);

        // random traffic against the job-queue model
        do_reset();
        for (int i = 0; i < NP; i++) begin
            owned[i] = 1'b0;
            fin[i] = 1'b0;
        end
        rr_m = 0;
        qp.delete();
        qs.delete();
        m_valid = 1'b0;
        for (int c = 0; c < 800; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_seq_id = 8'($urandom);
            pipe_not_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            sw_pipe_disable = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            out_ready = ($urandom_range(0, 2) != 0);
            pd = 2'b00;
            for (int i = 0; i < NP; i++) begin
                pd[i] = owned[i] && !fin[i] && ($urandom_range(0, 2) == 0);
            end
            pipe_done = pd;
            #1;
            grant = -1;
            for (int k = 0; k < NP; k++) begin
                m_p = (rr_m + k) % NP;
                if (grant < 0 && !owned[m_p] && !pipe_not_ready[m_p] && (m_p == 0 || !sw_pipe_disable[m_p]))
                    grant = m_p;
            end
            exp_rdy = (grant >= 0);
            chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
            for (int i = 0; i < NP; i++) begin
                if (pd[i]) fin[i] = 1'b1;
            end
            if (m_valid && out_ready) begin
                owned[qp[0]] = 1'b0;
                fin[qp[0]] = 1'b0;
                void'(qp.pop_front());
                void'(qs.pop_front());
            end
            exp_start = 0;
            exp_sseq = 0;
            if (req_valid && exp_rdy) begin
                owned[grant] = 1'b1;
                qp.push_back(grant);
                qs.push_back(int'(req_seq_id));
                rr_m = (grant + 1) % NP;
                exp_start = 1 << grant;
                exp_sseq = int'(req_seq_id);
            end
            m_valid = (qp.size() > 0) && fin[qp[0]];
            cyc();
            chk("rnd_start", 32'(pipe_start), 32'(exp_start));
            chk("rnd_start_seq", 32'(pipe_start_seq_id), 32'(exp_sseq));
            chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
            chk("rnd_out_sel", 32'(out_pipe_sel), m_valid ? 32'(1 << qp[0]) : 32'd0);
            chk("rnd_out_seq", 32'(out_seq_id), m_valid ? 32'(qs[0]) : 32'd0);
            chk("rnd_err", 32'(err_spurious_done), 32'd0);
        end

`ifdef CR_HUF_COMP_HTB_SCHED_STATS_EN
        do_reset();
        sw_pipe_disable = 2'b10;
        for (int j = 0; j < 5; j++) begin
            req_valid = 1'b1;
            req_seq_id = 8'(8'h70 + j);
            cyc();
            req_valid = 1'b0;
            pipe_done = 2'b01;
            cyc();
            pipe_done = 2'b00;
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
        end
        pipe_not_ready = 2'b11;
        req_valid = 1'b1;
        repeat (3) cyc();
        req_valid = 1'b0;
        pipe_not_ready = 2'b00;
        cyc();
        chk("stat_disp0", 32'(stat_dispatch_cnt[15:0]), 32'd5);
        chk("stat_disp1", 32'(stat_dispatch_cnt[31:16]), 32'd0);
        chk("stat_stall", 32'(stat_stall_cnt), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
